// File: rtl/ram_pkg.sv
// Shared types and helpers for the dual-port RAM and its init sweep.
package ram_pkg;

    localparam int unsigned PAR_MAX_W = 64;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_t;

    // Even parity of one lane; callers zero-extend the lane, which leaves parity unchanged.
    function automatic logic lane_parity(input logic [PAR_MAX_W-1:0] lane);
        return ^lane;
    endfunction

endpackage

// File: rtl/ram_dp_init.sv
// Post-reset init sweep: walks every address once and reports busy until done.
module ram_dp_init
    import ram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset_n,
    output logic                  busy,
    output logic                  sweep_we,
    output logic [ADDR_WIDTH-1:0] sweep_addr
);

    localparam int unsigned CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] LAST = {1'b0, {ADDR_WIDTH{1'b1}}};

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= INIT;
            cnt   <= '0;
            busy  <= 1'b1;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            busy  <= (state_next == INIT);
        end
    end

    // One address per cycle; the extra counter bit keeps the terminal value from wrapping.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            INIT: begin
                cnt_next = cnt + CW'(1);
                if (cnt == LAST) begin
                    state_next = READY;
                end
            end
            READY: begin
                state_next = READY;
            end
            default: begin
                state_next = INIT;
            end
        endcase
    end

    assign sweep_we   = busy;
    assign sweep_addr = cnt[ADDR_WIDTH-1:0];

endmodule

// File: rtl/ram_dp.sv
// True dual-port RAM with byte lanes, init sweep after reset and optional
// per-lane even parity (enabled by defining RAM_DP_PARITY_EN).
module ram_dp
    import ram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned LANES      = 1,
    parameter logic [DATA_WIDTH/LANES-1:0] INIT_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  a_enable,
    input  logic [LANES-1:0]      a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_di,
    output logic [DATA_WIDTH-1:0] a_do,
    output logic                  a_perr,
    input  logic                  b_enable,
    input  logic [LANES-1:0]      b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_di,
    output logic [DATA_WIDTH-1:0] b_do,
    output logic                  b_perr,
    output logic                  busy
);

    localparam int unsigned LW    = DATA_WIDTH / LANES;
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  sweep_we;
    logic [ADDR_WIDTH-1:0] sweep_addr;
    logic                  a_req;
    logic                  b_req;
    logic [DATA_WIDTH-1:0] a_merge;
    logic [DATA_WIDTH-1:0] b_merge;

    ram_dp_init #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_init (
        .clk        (clk),
        .reset_n    (reset_n),
        .busy       (busy),
        .sweep_we   (sweep_we),
        .sweep_addr (sweep_addr)
    );

    assign a_req = a_enable & ~busy;
    assign b_req = b_enable & ~busy;

    // Array write: sweep owns the array while busy; A is applied after B so A wins a lane collision.
    always_ff @(posedge clk) begin
        if (sweep_we) begin
            mem[sweep_addr] <= {LANES{INIT_VALUE}};
        end else begin
            for (int l = 0; l < LANES; l++) begin
                if (b_enable && b_we[l]) begin
                    mem[b_addr][l*LW +: LW] <= b_di[l*LW +: LW];
                end
            end
            for (int l = 0; l < LANES; l++) begin
                if (a_enable && a_we[l]) begin
                    mem[a_addr][l*LW +: LW] <= a_di[l*LW +: LW];
                end
            end
        end
    end

    // Own-port write-first merge; the other port's write is never visible this cycle.
    always_comb begin
        a_merge = mem[a_addr];
        b_merge = mem[b_addr];
        for (int l = 0; l < LANES; l++) begin
            if (a_we[l]) begin
                a_merge[l*LW +: LW] = a_di[l*LW +: LW];
            end
            if (b_we[l]) begin
                b_merge[l*LW +: LW] = b_di[l*LW +: LW];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_do <= '0;
            b_do <= '0;
        end else begin
            a_do <= a_req ? a_merge : '0;
            b_do <= b_req ? b_merge : '0;
        end
    end

`ifdef RAM_DP_PARITY_EN
    logic [LANES-1:0] par [DEPTH];
    logic             a_mis;
    logic             b_mis;

    always_ff @(posedge clk) begin
        if (sweep_we) begin
            par[sweep_addr] <= {LANES{lane_parity(PAR_MAX_W'(INIT_VALUE))}};
        end else begin
            for (int l = 0; l < LANES; l++) begin
                if (b_enable && b_we[l]) begin
                    par[b_addr][l] <= lane_parity(PAR_MAX_W'(b_di[l*LW +: LW]));
                end
            end
            for (int l = 0; l < LANES; l++) begin
                if (a_enable && a_we[l]) begin
                    par[a_addr][l] <= lane_parity(PAR_MAX_W'(a_di[l*LW +: LW]));
                end
            end
        end
    end

    // Only stored lanes can mismatch; freshly written lanes carry matching parity.
    always_comb begin
        a_mis = 1'b0;
        b_mis = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            if (!a_we[l] &&
                (par[a_addr][l] != lane_parity(PAR_MAX_W'(mem[a_addr][l*LW +: LW])))) begin
                a_mis = 1'b1;
            end
            if (!b_we[l] &&
                (par[b_addr][l] != lane_parity(PAR_MAX_W'(mem[b_addr][l*LW +: LW])))) begin
                b_mis = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_perr <= 1'b0;
            b_perr <= 1'b0;
        end else begin
            a_perr <= a_req & a_mis;
            b_perr <= b_req & b_mis;
        end
    end
`else
    assign a_perr = 1'b0;
    assign b_perr = 1'b0;
`endif

endmodule

// File: tb/tb_ram_dp.sv
// Directed bench for ram_dp: 16-deep, 16-bit, two byte lanes, init value 8'h16.
`timescale 1ns/1ps
module tb_ram_dp;

    localparam int unsigned AW = 4;
    localparam int unsigned DW = 16;
    localparam int unsigned NL = 2;
    localparam int unsigned NV = 15;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          a_enable, b_enable;
    logic [NL-1:0] a_we, b_we;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_di, b_di;
    logic [DW-1:0] a_do, b_do;
    logic          a_perr, b_perr;
    logic          busy;

    int total = 0;
    int bad   = 0;

    ram_dp #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .LANES      (NL),
        .INIT_VALUE (8'h16)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .a_enable (a_enable),
        .a_we     (a_we),
        .a_addr   (a_addr),
        .a_di     (a_di),
        .a_do     (a_do),
        .a_perr   (a_perr),
        .b_enable (b_enable),
        .b_we     (b_we),
        .b_addr   (b_addr),
        .b_di     (b_di),
        .b_do     (b_do),
        .b_perr   (b_perr),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          a_en;
        logic [NL-1:0] a_we;
        logic [AW-1:0] a_addr;
        logic [DW-1:0] a_di;
        logic          b_en;
        logic [NL-1:0] b_we;
        logic [AW-1:0] b_addr;
        logic [DW-1:0] b_di;
        logic          chk_b;
        logic [DW-1:0] exp_a;
        logic [DW-1:0] exp_b;
    } vec_t;

    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ae, input logic [NL-1:0] awe, input logic [AW-1:0] aad,
                         input logic [DW-1:0] adi, input logic be, input logic [NL-1:0] bwe,
                         input logic [AW-1:0] bad_addr, input logic [DW-1:0] bdi);
        a_enable = ae;  a_we = awe; a_addr = aad;      a_di = adi;
        b_enable = be;  b_we = bwe; b_addr = bad_addr; b_di = bdi;
    endtask

    // Junk requests on both ports while busy; outputs must stay zero throughout.
    task automatic count_busy(input string name);
        int  n;
        logic dirty;
        n = 0;
        dirty = 1'b0;
        drive(1'b1, 2'b11, 4'd0, 16'hFFFF, 1'b1, 2'b11, 4'd15, 16'hFFFF);
        for (int i = 0; i < 64; i++) begin
            step();
            n++;
            if (a_do !== 16'h0 || b_do !== 16'h0) dirty = 1'b1;
            if (busy === 1'b0) break;
        end
        check({name, "_busy_cycles"}, 32'(n), 32'd16);
        check({name, "_do_zero"}, {31'd0, dirty}, 32'd0);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 2'b11, 4'd1,  16'hABCD, 1'b0, 2'b00, 4'd0,  16'h0000, 1'b1, 16'hABCD, 16'h0000};
        vecs[1]  = '{1'b1, 2'b01, 4'd1,  16'h1234, 1'b1, 2'b00, 4'd1,  16'h0000, 1'b1, 16'hAB34, 16'hABCD};
        vecs[2]  = '{1'b1, 2'b00, 4'd1,  16'h0000, 1'b0, 2'b00, 4'd0,  16'h0000, 1'b1, 16'hAB34, 16'h0000};
        vecs[3]  = '{1'b0, 2'b00, 4'd0,  16'h0000, 1'b1, 2'b10, 4'd2,  16'h5678, 1'b1, 16'h0000, 16'h5616};
        vecs[4]  = '{1'b1, 2'b00, 4'd2,  16'h0000, 1'b1, 2'b00, 4'd2,  16'h0000, 1'b1, 16'h5616, 16'h5616};
        vecs[5]  = '{1'b1, 2'b11, 4'd5,  16'h1111, 1'b1, 2'b11, 4'd5,  16'h2222, 1'b0, 16'h1111, 16'h0000};
        vecs[6]  = '{1'b1, 2'b00, 4'd5,  16'h0000, 1'b1, 2'b00, 4'd5,  16'h0000, 1'b1, 16'h1111, 16'h1111};
        vecs[7]  = '{1'b1, 2'b01, 4'd6,  16'hAA11, 1'b1, 2'b11, 4'd6,  16'h2222, 1'b0, 16'h1611, 16'h0000};
        vecs[8]  = '{1'b1, 2'b00, 4'd6,  16'h0000, 1'b1, 2'b00, 4'd6,  16'h0000, 1'b1, 16'h2211, 16'h2211};
        vecs[9]  = '{1'b1, 2'b11, 4'd3,  16'h5555, 1'b1, 2'b00, 4'd3,  16'h0000, 1'b1, 16'h5555, 16'h1616};
        vecs[10] = '{1'b1, 2'b00, 4'd3,  16'h0000, 1'b0, 2'b11, 4'd3,  16'h0000, 1'b1, 16'h5555, 16'h0000};
        vecs[11] = '{1'b0, 2'b11, 4'd3,  16'h0000, 1'b1, 2'b00, 4'd3,  16'h0000, 1'b1, 16'h0000, 16'h5555};
        vecs[12] = '{1'b1, 2'b00, 4'd3,  16'h0000, 1'b0, 2'b00, 4'd0,  16'h0000, 1'b1, 16'h5555, 16'h0000};
        vecs[13] = '{1'b1, 2'b10, 4'd15, 16'hBEEF, 1'b1, 2'b00, 4'd0,  16'h0000, 1'b1, 16'hBE16, 16'h1616};
        vecs[14] = '{1'b1, 2'b00, 4'd15, 16'h0000, 1'b1, 2'b00, 4'd15, 16'h0000, 1'b1, 16'hBE16, 16'hBE16};

        drive(1'b1, 2'b11, 4'd0, 16'hFFFF, 1'b1, 2'b11, 4'd15, 16'hFFFF);

        // Reset asserted: outputs forced and held across clock edges.
        #1 reset_n = 1'b0;
        #2;
        check("rst_a_do", 32'(a_do), 32'h0);
        check("rst_b_do", 32'(b_do), 32'h0);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_perr", {30'd0, a_perr, b_perr}, 32'd0);
        repeat (3) step();
        check("rst_hold", {15'd0, busy, a_do}, {15'd0, 1'b1, 16'h0});
        reset_n = 1'b1;

        count_busy("init");

        // First READY cycle onward: every address holds the init pattern.
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 2'b00, 4'(i), 16'h0, 1'b1, 2'b00, 4'(15 - i), 16'h0);
            step();
            check($sformatf("init_rd_a%0d", i), 32'(a_do), 32'h1616);
            check($sformatf("init_rd_b%0d", 15 - i), 32'(b_do), 32'h1616);
        end

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].a_en, vecs[i].a_we, vecs[i].a_addr, vecs[i].a_di,
                  vecs[i].b_en, vecs[i].b_we, vecs[i].b_addr, vecs[i].b_di);
            step();
            check($sformatf("vec%0d_a_do", i), 32'(a_do), 32'(vecs[i].exp_a));
            if (vecs[i].chk_b) check($sformatf("vec%0d_b_do", i), 32'(b_do), 32'(vecs[i].exp_b));
            check($sformatf("vec%0d_perr", i), {30'd0, a_perr, b_perr}, 32'd0);
        end

        // Asynchronous reset mid-operation clears outputs at once and restarts the sweep.
        #2 reset_n = 1'b0;
        #1;
        check("midop_rst_a_do", 32'(a_do), 32'h0);
        check("midop_rst_b_do", 32'(b_do), 32'h0);
        check("midop_rst_busy", 32'(busy), 32'd1);
        #1 reset_n = 1'b1;
        drive(1'b0, 2'b00, 4'd0, 16'h0, 1'b0, 2'b00, 4'd0, 16'h0);
        repeat (7) step();
        check("midsweep_busy7", 32'(busy), 32'd1);

        // Reset pulse at sweep cycle 7: a full fresh sweep follows.
        reset_n = 1'b0;
        #2 reset_n = 1'b1;
        count_busy("resweep");

        drive(1'b1, 2'b00, 4'd15, 16'h0, 1'b1, 2'b00, 4'd1, 16'h0);
        step();
        check("resweep_rd15", 32'(a_do), 32'h1616);
        check("resweep_rd1", 32'(b_do), 32'h1616);

`ifdef RAM_DP_PARITY_EN
        drive(1'b0, 2'b00, 4'd0, 16'h0, 1'b0, 2'b00, 4'd0, 16'h0);
        step();
        dut.mem[2] = dut.mem[2] ^ 16'h0100;
        drive(1'b1, 2'b00, 4'd2, 16'h0, 1'b1, 2'b00, 4'd3, 16'h0);
        step();
        check("par_flip_a_perr", 32'(a_perr), 32'd1);
        check("par_flip_a_do", 32'(a_do), 32'h1716);
        check("par_clean_b_perr", 32'(b_perr), 32'd0);
        drive(1'b0, 2'b00, 4'd2, 16'h0, 1'b0, 2'b00, 4'd3, 16'h0);
        step();
        check("par_off_a_perr", 32'(a_perr), 32'd0);
        check("par_off_a_do", 32'(a_do), 32'h0);
`else
        drive(1'b1, 2'b00, 4'd2, 16'h0, 1'b1, 2'b00, 4'd3, 16'h0);
        step();
        check("nopar_rd_perr", {30'd0, a_perr, b_perr}, 32'd0);
        drive(1'b0, 2'b00, 4'd2, 16'h0, 1'b0, 2'b00, 4'd3, 16'h0);
        step();
        check("nopar_off_perr", {30'd0, a_perr, b_perr}, 32'd0);
        check("nopar_off_do", 32'(a_do), 32'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_dp.md
RAM_DP -- requirements
Module: ram_dp

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10: word address width; depth = 2**ADDR_WIDTH.
REQ-002 SHALL have parameter DATA_WIDTH, default 8: word width.
REQ-003 SHALL have parameter LANES, default 1: byte-write lanes; DATA_WIDTH mod LANES = 0, lane width LW = DATA_WIDTH/LANES.
REQ-004 SHALL have parameter INIT_VALUE, default 0: LW-bit value written to every lane by the init sweep.
REQ-005 SHALL have port clk, input, 1: single clock, all logic on rising edge.
REQ-006 SHALL have port reset_n, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port a_enable / b_enable, input, 1 each: port access request.
REQ-008 SHALL have port a_we / b_we, input, LANES each: per-lane write enable, valid only with the port enable.
REQ-009 SHALL have port a_addr / b_addr, input, ADDR_WIDTH each: word address.
REQ-010 SHALL have port a_di / b_di, input, DATA_WIDTH each: write data.
REQ-011 SHALL have port a_do / b_do, output, DATA_WIDTH each: registered read data.
REQ-012 SHALL have port a_perr / b_perr, output, 1 each: parity error flag, aligned with *_do.
REQ-013 SHALL have port busy, output, 1: init sweep in progress; ports ignored.

Function
REQ-014 Read latency SHALL be 1 cycle: enable and addr sampled at edge N, *_do valid after edge N.
REQ-015 A port not enabled SHALL drive *_do = 0 and *_perr = 0 the next cycle.
REQ-016 A write SHALL update only the lanes with *_we set; other lanes SHALL keep their contents.
REQ-017 On a port's own write cycle, *_do SHALL be write-first: written lanes show new data, unwritten lanes show stored data.
REQ-018 Cross-port read of an address written by the other port in the same cycle SHALL return old data (read-first).
REQ-019 Both ports writing the same lane of the same address in one cycle SHALL leave port A's data; port B's write to that lane is dropped.
REQ-020 The FSM SHALL have states INIT and READY; the FSM SHALL enter INIT on reset.
REQ-021 In INIT, the FSM SHALL write INIT_VALUE to all lanes of address 0, 1, ... 2**ADDR_WIDTH-1, one address per cycle.
REQ-022 In INIT, busy SHALL be 1, port inputs SHALL be ignored, and both *_do SHALL be 0.
REQ-023 After the last address is written, the FSM SHALL go to READY; busy SHALL be 0 from the following cycle; the total sweep is exactly 2**ADDR_WIDTH cycles.
REQ-024 The sweep counter SHALL be ADDR_WIDTH+1 bits, with no wrap-around before terminal.
REQ-025 Port requests in the first READY cycle SHALL be serviced normally.

Reset
REQ-026 Asserting reset_n low SHALL immediately force: *_do = 0, *_perr = 0, busy = 1, FSM = INIT, sweep counter = 0.
REQ-027 Reset mid-sweep or mid-operation SHALL restart the sweep from address 0 after release.
REQ-028 Memory array contents SHALL not be reset directly; the sweep alone defines them.

Configuration
REQ-029 With macro RAM_DP_PARITY_EN defined, the RAM SHALL store one even-parity bit per lane, written on every lane write (including the sweep).
REQ-030 With RAM_DP_PARITY_EN defined, *_perr SHALL be the OR of per-lane parity mismatches of the read word, registered with *_do.
REQ-031 With RAM_DP_PARITY_EN defined, *_perr SHALL be 0 when *_do is forced to 0.
REQ-032 Without RAM_DP_PARITY_EN, no parity storage SHALL exist, and a_perr and b_perr SHALL be constant 0; the ports remain present.

Structure
REQ-033 Shared package ram_pkg SHALL hold the state enum {INIT, READY} and the lane parity function.
REQ-034 Sub-module ram_dp_init SHALL hold the sweep FSM and counter, outputting busy, sweep address and sweep write strobe.

Verification
REQ-035 Init scenario: ADDR_WIDTH=4, INIT_VALUE=8'h16; release reset -> busy high exactly 16 cycles; A reads addr 0..15 -> 8'h16 each.
REQ-036 Byte-lane write scenario: DATA_WIDTH=16, LANES=2; A writes 16'hABCD, then 16'h1234 with a_we=2'b01 -> a_do 16'hAB34 on the write cycle and on a later read.
REQ-037 Collision scenario: same cycle, A writes 8'h11 and B writes 8'h22 to addr 5 -> addr 5 reads 8'h11.
REQ-038 Cross-port read scenario: B reads addr 3 (holds 8'h16) while A writes 8'h55 there -> b_do=8'h16 and a_do=8'h55.
REQ-039 Reset-mid-sweep scenario: pulse reset_n at sweep cycle 7 -> busy stays high for a further full 16 cycles after release.
REQ-040 Parity scenario: with RAM_DP_PARITY_EN, force a stored bit flip at addr 2 -> the read gives a_perr=1; with enable low, a_perr=0.
